// File: rtl/param_reorder_buffer_if.sv
// Bundle of issue, write-back, retire, store handshake, flush and operand
// lookup signals between the reorder buffer and its surrounding pipeline.
interface param_reorder_buffer_if #(
  parameter int ROB_BITS = 3,
  parameter int WB_PORTS = 2
);
  logic                         rdy;
  logic                         issue_valid;
  logic [1:0]                   issue_type;
  logic [4:0]                   issue_rd;
  logic                         issue_done;
  logic [31:0]                  issue_value;
  logic                         issue_pred;
  logic [31:0]                  issue_alt_pc;
  logic                         full;
  logic                         empty;
  logic [ROB_BITS:0]            count;
  logic [ROB_BITS-1:0]          head_id;
  logic [ROB_BITS-1:0]          tail_id;
  logic [WB_PORTS-1:0]          wb_valid;
  logic [WB_PORTS*ROB_BITS-1:0] wb_id;
  logic [WB_PORTS*32-1:0]       wb_value;
  logic                         commit_valid;
  logic [4:0]                   commit_rd;
  logic [31:0]                  commit_value;
  logic [ROB_BITS-1:0]          commit_id;
  logic                         st_valid;
  logic [ROB_BITS-1:0]          st_id;
  logic                         st_ack;
  logic                         flush;
  logic [31:0]                  flush_pc;
  logic [ROB_BITS-1:0]          q_id1;
  logic [ROB_BITS-1:0]          q_id2;
  logic                         q_rdy1;
  logic                         q_rdy2;
  logic [31:0]                  q_val1;
  logic [31:0]                  q_val2;

  modport master (
    output rdy, issue_valid, issue_type, issue_rd, issue_done, issue_value,
           issue_pred, issue_alt_pc, wb_valid, wb_id, wb_value, st_ack,
           q_id1, q_id2,
    input  full, empty, count, head_id, tail_id, commit_valid, commit_rd,
           commit_value, commit_id, st_valid, st_id, flush, flush_pc,
           q_rdy1, q_rdy2, q_val1, q_val2
  );

  modport slave (
    input  rdy, issue_valid, issue_type, issue_rd, issue_done, issue_value,
           issue_pred, issue_alt_pc, wb_valid, wb_id, wb_value, st_ack,
           q_id1, q_id2,
    output full, empty, count, head_id, tail_id, commit_valid, commit_rd,
           commit_value, commit_id, st_valid, st_id, flush, flush_pc,
           q_rdy1, q_rdy2, q_val1, q_val2
  );
endinterface

// File: rtl/param_reorder_buffer.sv
// In-order retirement buffer with multi-port write-back, store handshake,
// branch mispredict flush and operand lookup.
//   state    | meaning
//   ST_RUN   | normal issue / write-back / retire
//   ST_FLUSH | mispredict seen; next enabled cycle clears every entry
module param_reorder_buffer #(
  parameter int ROB_BITS = 3,
  parameter int WB_PORTS = 2
) (
  input logic                  clk,
  input logic                  rst,
  param_reorder_buffer_if.slave bus
);
  localparam int DEPTH = 1 << ROB_BITS;
  localparam int CW    = ROB_BITS + 1;
  localparam logic [1:0] TY_R = 2'd0;
  localparam logic [1:0] TY_B = 2'd1;
  localparam logic [1:0] TY_S = 2'd2;

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

  state_t state, state_nxt;

  logic [DEPTH-1:0]    busy, done, ent_pred;
  logic [1:0]          ent_type   [DEPTH];
  logic [4:0]          ent_rd     [DEPTH];
  logic [31:0]         ent_value  [DEPTH];
  logic [31:0]         ent_alt_pc [DEPTH];
  logic [ROB_BITS-1:0] head, tail;
  logic [CW-1:0]       count;
  logic [31:0]         flush_pc_r;

  logic [ROB_BITS-1:0] wb_idx [WB_PORTS];
  logic [31:0]         wb_val [WB_PORTS];

  logic running, full_w, issue_acc, head_ready, st_pending, retire, mispredict;

  always_comb begin
    for (int k = 0; k < WB_PORTS; k++) begin
      wb_idx[k] = bus.wb_id[k*ROB_BITS +: ROB_BITS];
      wb_val[k] = bus.wb_value[k*32 +: 32];
    end
  end

  always_comb begin
    full_w     = (count == CW'(DEPTH));
    running    = bus.rdy && (state == ST_RUN);
    issue_acc  = running && bus.issue_valid && !full_w;
    head_ready = busy[head] && done[head];
    st_pending = running && head_ready && (ent_type[head] == TY_S);
    retire     = running && head_ready && ((ent_type[head] != TY_S) || bus.st_ack);
    mispredict = retire && (ent_type[head] == TY_B) &&
                 (ent_value[head][0] != ent_pred[head]);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:   if (mispredict) state_nxt = ST_FLUSH;
      ST_FLUSH: if (bus.rdy)    state_nxt = ST_RUN;
      default:  state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_RUN;
      flush_pc_r <= '0;
    end else begin
      state <= state_nxt;
      if (mispredict) flush_pc_r <= ent_alt_pc[head];
    end
  end

  // Write-backs first so a same-cycle retire clear of the head wins;
  // later ports override earlier ones on a shared id.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      busy     <= '0;
      done     <= '0;
      ent_pred <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_type[i]   <= '0;
        ent_rd[i]     <= '0;
        ent_value[i]  <= '0;
        ent_alt_pc[i] <= '0;
      end
    end else if (bus.rdy) begin
      if (state == ST_FLUSH) begin
        busy  <= '0;
        done  <= '0;
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        for (int k = 0; k < WB_PORTS; k++) begin
          if (bus.wb_valid[k] && busy[wb_idx[k]]) begin
            ent_value[wb_idx[k]] <= wb_val[k];
            done[wb_idx[k]]      <= 1'b1;
          end
        end
        if (retire) begin
          busy[head] <= 1'b0;
          done[head] <= 1'b0;
          head       <= head + ROB_BITS'(1);
        end
        if (issue_acc) begin
          busy[tail]       <= 1'b1;
          done[tail]       <= bus.issue_done;
          ent_type[tail]   <= bus.issue_type;
          ent_rd[tail]     <= bus.issue_rd;
          ent_value[tail]  <= bus.issue_value;
          ent_pred[tail]   <= bus.issue_pred;
          ent_alt_pc[tail] <= bus.issue_alt_pc;
          tail             <= tail + ROB_BITS'(1);
        end
        count <= count + CW'(issue_acc) - CW'(retire);
      end
    end
  end

  logic        q_hit1, q_hit2;
  logic [31:0] q_wb1, q_wb2;

  always_comb begin
    q_hit1 = 1'b0;
    q_hit2 = 1'b0;
    q_wb1  = '0;
    q_wb2  = '0;
    for (int k = 0; k < WB_PORTS; k++) begin
      if (bus.wb_valid[k] && (wb_idx[k] == bus.q_id1)) begin
        q_hit1 = 1'b1;
        q_wb1  = wb_val[k];
      end
      if (bus.wb_valid[k] && (wb_idx[k] == bus.q_id2)) begin
        q_hit2 = 1'b1;
        q_wb2  = wb_val[k];
      end
    end
  end

  assign bus.q_rdy1 = done[bus.q_id1] || q_hit1;
  assign bus.q_rdy2 = done[bus.q_id2] || q_hit2;
  assign bus.q_val1 = done[bus.q_id1] ? ent_value[bus.q_id1] : (q_hit1 ? q_wb1 : 32'd0);
  assign bus.q_val2 = done[bus.q_id2] ? ent_value[bus.q_id2] : (q_hit2 ? q_wb2 : 32'd0);

  assign bus.full         = full_w;
  assign bus.empty        = (count == '0);
  assign bus.count        = count;
  assign bus.head_id      = head;
  assign bus.tail_id      = tail;
  assign bus.commit_valid = retire && (ent_type[head] == TY_R) && (ent_rd[head] != 5'd0);
  assign bus.commit_rd    = ent_rd[head];
  assign bus.commit_value = ent_value[head];
  assign bus.commit_id    = head;
  assign bus.st_valid     = st_pending;
  assign bus.st_id        = head;
  assign bus.flush        = (state == ST_FLUSH);
  assign bus.flush_pc     = flush_pc_r;
endmodule

// File: tb/tb_param_reorder_buffer.sv
// Directed bench for the reorder buffer: fill/wrap, out-of-order write-back,
// mispredict flush, store handshake, port priority and reset/freeze.
module tb_param_reorder_buffer;
  localparam int RB = 3;
  localparam int WP = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  param_reorder_buffer_if #(.ROB_BITS(RB), .WB_PORTS(WP)) bus ();
  param_reorder_buffer #(.ROB_BITS(RB), .WB_PORTS(WP)) dut (.clk(clk), .rst(rst), .bus(bus));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    bus.rdy          = 1'b1;
    bus.issue_valid  = 1'b0;
    bus.issue_type   = 2'd0;
    bus.issue_rd     = 5'd0;
    bus.issue_done   = 1'b0;
    bus.issue_value  = 32'd0;
    bus.issue_pred   = 1'b0;
    bus.issue_alt_pc = 32'd0;
    bus.wb_valid     = '0;
    bus.wb_id        = '0;
    bus.wb_value     = '0;
    bus.st_ack       = 1'b0;
    bus.q_id1        = '0;
    bus.q_id2        = '0;
  endtask

  task automatic issue(input logic [1:0] ty, input logic [4:0] rd, input logic dn,
                       input logic [31:0] v, input logic pr, input logic [31:0] alt);
    bus.issue_valid  = 1'b1;
    bus.issue_type   = ty;
    bus.issue_rd     = rd;
    bus.issue_done   = dn;
    bus.issue_value  = v;
    bus.issue_pred   = pr;
    bus.issue_alt_pc = alt;
  endtask

  task automatic wb_set(input int k, input logic [RB-1:0] id, input logic [31:0] v);
    bus.wb_valid[k]         = 1'b1;
    bus.wb_id[k*RB +: RB]   = id;
    bus.wb_value[k*32 +: 32] = v;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    settle();
    chk("rst_empty", bus.empty, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_head", bus.head_id, 0);
    chk("rst_tail", bus.tail_id, 0);
    chk("rst_commit_valid", bus.commit_valid, 0);
    chk("rst_st_valid", bus.st_valid, 0);
    chk("rst_flush", bus.flush, 0);
    chk("rst_flush_pc", bus.flush_pc, 0);
    rst = 1'b0;
    step();

    // fill all eight entries, then a ninth attempt is refused
    for (int i = 0; i < 8; i++) begin
      issue(2'd0, 5'(i + 1), 1'b0, 32'd0, 1'b0, 32'd0);
      settle();
      chk("fill_tail_id", bus.tail_id, i);
      chk("fill_count", bus.count, i);
      step();
    end
    issue(2'd0, 5'd9, 1'b0, 32'd0, 1'b0, 32'd0);
    settle();
    chk("full_flag", bus.full, 1);
    chk("full_count", bus.count, 8);
    chk("full_tail_wrap", bus.tail_id, 0);
    step();
    bus.issue_valid = 1'b0;
    settle();
    chk("ninth_ignored_count", bus.count, 8);
    chk("ninth_ignored_tail", bus.tail_id, 0);
    chk("ninth_head", bus.head_id, 0);
    chk("ninth_no_commit", bus.commit_valid, 0);

    // out-of-order write-back, in-order commit
    wb_set(0, 3'd2, 32'h22);
    settle();
    chk("ooo_wb2_no_commit", bus.commit_valid, 0);
    step();
    wb_set(0, 3'd0, 32'h00);
    settle();
    chk("ooo_wb0_no_commit", bus.commit_valid, 0);
    step();
    wb_set(0, 3'd1, 32'h11);
    settle();
    chk("ooo_c0_valid", bus.commit_valid, 1);
    chk("ooo_c0_id", bus.commit_id, 0);
    chk("ooo_c0_rd", bus.commit_rd, 1);
    chk("ooo_c0_value", bus.commit_value, 32'h00);
    step();
    bus.wb_valid = '0;
    settle();
    chk("ooo_c1_valid", bus.commit_valid, 1);
    chk("ooo_c1_id", bus.commit_id, 1);
    chk("ooo_c1_rd", bus.commit_rd, 2);
    chk("ooo_c1_value", bus.commit_value, 32'h11);
    step();
    settle();
    chk("ooo_c2_valid", bus.commit_valid, 1);
    chk("ooo_c2_id", bus.commit_id, 2);
    chk("ooo_c2_rd", bus.commit_rd, 3);
    chk("ooo_c2_value", bus.commit_value, 32'h22);
    step();
    settle();
    chk("ooo_stall_commit", bus.commit_valid, 0);
    chk("ooo_stall_count", bus.count, 5);
    chk("ooo_stall_head", bus.head_id, 3);

    rst = 1'b1;
    settle();
    chk("midrst_count", bus.count, 0);
    chk("midrst_empty", bus.empty, 1);
    chk("midrst_tail", bus.tail_id, 0);
    step();
    rst = 1'b0;

    // two ports hit the same id: the higher port wins
    issue(2'd0, 5'd5, 1'b0, 32'd0, 1'b0, 32'd0);
    step();
    bus.issue_valid = 1'b0;
    wb_set(0, 3'd0, 32'hA);
    wb_set(1, 3'd0, 32'hB);
    bus.q_id1 = 3'd0;
    bus.q_id2 = 3'd1;
    settle();
    chk("dual_q_rdy1", bus.q_rdy1, 1);
    chk("dual_q_val1", bus.q_val1, 32'hB);
    chk("dual_q_rdy2", bus.q_rdy2, 0);
    chk("dual_q_val2", bus.q_val2, 0);
    chk("dual_no_commit", bus.commit_valid, 0);
    step();
    bus.wb_valid = '0;
    settle();
    chk("dual_stored_q_rdy1", bus.q_rdy1, 1);
    chk("dual_stored_q_val1", bus.q_val1, 32'hB);
    chk("dual_commit_valid", bus.commit_valid, 1);
    chk("dual_commit_value", bus.commit_value, 32'hB);
    chk("dual_commit_rd", bus.commit_rd, 5);
    step();

    // done-at-issue entry retires the following cycle
    issue(2'd0, 5'd7, 1'b1, 32'h77, 1'b0, 32'd0);
    settle();
    chk("lat_issue_cycle_commit", bus.commit_valid, 0);
    step();
    bus.issue_valid = 1'b0;
    settle();
    chk("lat_commit_valid", bus.commit_valid, 1);
    chk("lat_commit_id", bus.commit_id, 1);
    chk("lat_commit_value", bus.commit_value, 32'h77);
    step();
    settle();
    chk("lat_empty", bus.empty, 1);

    // rd=0 retires without a commit strobe
    issue(2'd0, 5'd0, 1'b1, 32'h5, 1'b0, 32'd0);
    step();
    bus.issue_valid = 1'b0;
    settle();
    chk("rd0_commit_valid", bus.commit_valid, 0);
    chk("rd0_count", bus.count, 1);
    chk("rd0_head", bus.head_id, 2);
    step();
    settle();
    chk("rd0_retired_count", bus.count, 0);
    chk("rd0_retired_head", bus.head_id, 3);

    // mispredicted branch: predicted taken, actually not taken
    issue(2'd1, 5'd0, 1'b0, 32'd0, 1'b1, 32'h100);
    step();
    bus.issue_valid = 1'b0;
    wb_set(0, 3'd3, 32'd0);
    settle();
    chk("br_wb_flush", bus.flush, 0);
    step();
    bus.wb_valid = '0;
    settle();
    chk("br_retire_flush", bus.flush, 0);
    chk("br_retire_count", bus.count, 1);
    step();
    settle();
    chk("br_flush", bus.flush, 1);
    chk("br_flush_pc", bus.flush_pc, 32'h100);
    chk("br_flush_count", bus.count, 0);
    bus.rdy = 1'b0;
    issue(2'd0, 5'd4, 1'b1, 32'h44, 1'b0, 32'd0);
    step();
    settle();
    chk("br_hold_flush", bus.flush, 1);
    bus.rdy = 1'b1;
    step();
    bus.issue_valid = 1'b0;
    settle();
    chk("br_after_flush", bus.flush, 0);
    chk("br_after_empty", bus.empty, 1);
    chk("br_after_count", bus.count, 0);
    chk("br_after_head", bus.head_id, 0);
    chk("br_after_tail", bus.tail_id, 0);

    // correctly predicted branch retires silently
    issue(2'd1, 5'd0, 1'b1, 32'd1, 1'b1, 32'h200);
    step();
    bus.issue_valid = 1'b0;
    settle();
    chk("brok_retire_count", bus.count, 1);
    step();
    settle();
    chk("brok_no_flush", bus.flush, 0);
    chk("brok_count", bus.count, 0);
    chk("brok_head", bus.head_id, 1);

    // store waits for ack; following entry must not retire early
    issue(2'd2, 5'd0, 1'b1, 32'd0, 1'b0, 32'd0);
    step();
    issue(2'd0, 5'd9, 1'b1, 32'h99, 1'b0, 32'd0);
    step();
    bus.issue_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("st_wait_valid", bus.st_valid, 1);
      chk("st_wait_id", bus.st_id, 1);
      chk("st_wait_no_commit", bus.commit_valid, 0);
      chk("st_wait_count", bus.count, 2);
      step();
    end
    bus.st_ack = 1'b1;
    settle();
    chk("st_ack_valid", bus.st_valid, 1);
    chk("st_ack_no_commit", bus.commit_valid, 0);
    step();
    bus.st_ack = 1'b0;
    settle();
    chk("st_after_valid", bus.st_valid, 0);
    chk("st_next_commit_valid", bus.commit_valid, 1);
    chk("st_next_commit_id", bus.commit_id, 2);
    chk("st_next_commit_rd", bus.commit_rd, 9);
    chk("st_next_commit_value", bus.commit_value, 32'h99);
    chk("st_next_count", bus.count, 1);
    step();
    settle();
    chk("st_drained", bus.empty, 1);

    // five entries with a pending store, freeze window, then reset
    issue(2'd2, 5'd0, 1'b1, 32'd0, 1'b0, 32'd0);
    step();
    for (int i = 0; i < 4; i++) begin
      issue(2'd0, 5'(i + 1), 1'b0, 32'd0, 1'b0, 32'd0);
      step();
    end
    bus.issue_valid = 1'b0;
    settle();
    chk("f5_count", bus.count, 5);
    chk("f5_st_valid", bus.st_valid, 1);
    chk("f5_st_id", bus.st_id, 3);
    chk("f5_tail", bus.tail_id, 0);
    bus.rdy = 1'b0;
    bus.st_ack = 1'b1;
    issue(2'd0, 5'd10, 1'b1, 32'd0, 1'b0, 32'd0);
    settle();
    chk("frz_st_valid", bus.st_valid, 0);
    chk("frz_commit_valid", bus.commit_valid, 0);
    step();
    step();
    settle();
    chk("frz_count", bus.count, 5);
    chk("frz_head", bus.head_id, 3);
    chk("frz_tail", bus.tail_id, 0);
    bus.rdy = 1'b1;
    bus.st_ack = 1'b0;
    bus.issue_valid = 1'b0;
    settle();
    chk("unfrz_st_valid", bus.st_valid, 1);
    rst = 1'b1;
    settle();
    chk("rst5_count", bus.count, 0);
    chk("rst5_st_valid", bus.st_valid, 0);
    chk("rst5_empty", bus.empty, 1);
    chk("rst5_full", bus.full, 0);
    chk("rst5_head", bus.head_id, 0);
    chk("rst5_tail", bus.tail_id, 0);
    chk("rst5_flush", bus.flush, 0);
    step();
    rst = 1'b0;
    settle();
    chk("rst5_release_empty", bus.empty, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
